// File: rtl/qupls_decode_sequencer.sv
// rtl/qupls_decode_sequencer.sv - handshake sequencer around the registered decoder with macro-op expansion
module qupls_decode_sequencer #(
    parameter int INSN_W    = 48,
    parameter int UOP_CNT_W = 4,
    parameter int PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_v,
    input  logic [INSN_W-1:0]    in_ins,
    output logic                 in_rdy,
    input  logic                 flush,
    output logic                 dec_en,
    output logic [INSN_W-1:0]    dec_ins,
    input  logic                 dec_macro,
    input  logic [UOP_CNT_W-1:0] dec_uop_cnt,
    input  logic                 dec_regexc,
    output logic                 out_v,
    input  logic                 out_rdy,
    output logic [UOP_CNT_W-1:0] out_uop_idx,
    output logic                 out_last,
    output logic                 out_exc,
    output logic [PERF_W-1:0]    perf_insn,
    output logic [PERF_W-1:0]    perf_uop
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [UOP_CNT_W-1:0] idx_q, idx_d;
    logic [UOP_CNT_W-1:0] cnt_q, cnt_live, cnt_eff;
    logic                 first_q;
    logic                 beat;

    // An exception or a zero count collapses the instruction to one beat.
    always_comb begin
        cnt_live = UOP_CNT_W'(1);
        if (!dec_regexc && dec_macro && dec_uop_cnt != '0)
            cnt_live = dec_uop_cnt;
    end

    // The first held cycle sees the live decoder count before it is latched.
    assign cnt_eff = first_q ? cnt_live : cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = EMPTY;
            idx_d   = '0;
        end else begin
            case (state_q)
                EMPTY: if (dec_en) state_d = HELD;
                HELD: begin
                    if (beat) begin
                        if (out_last) begin
                            idx_d = '0;
                            if (!dec_en) state_d = EMPTY;
                        end else begin
                            idx_d = idx_q + UOP_CNT_W'(1);
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_v       = (state_q == HELD);
        out_uop_idx = idx_q;
        out_last    = (idx_q == cnt_eff - UOP_CNT_W'(1));
        out_exc     = out_v && dec_regexc;
        beat        = out_v && out_rdy && !flush;
        in_rdy      = !flush && (state_q == EMPTY || (out_rdy && out_last));
        dec_en      = in_v && in_rdy;
        dec_ins     = in_ins;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            cnt_q     <= UOP_CNT_W'(1);
            first_q   <= 1'b0;
            perf_insn <= '0;
            perf_uop  <= '0;
        end else begin
            idx_q   <= idx_d;
            first_q <= !flush && dec_en;
            if (first_q)
                cnt_q <= cnt_live;
            if (beat) begin
                perf_uop <= perf_uop + PERF_W'(1);
                if (out_last)
                    perf_insn <= perf_insn + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_qupls_decode_sequencer.sv
// tb/tb_qupls_decode_sequencer.sv - randomized bench for qupls_decode_sequencer against a transaction model
module tb_qupls_decode_sequencer;

    localparam int INSN_W    = 48;
    localparam int UOP_CNT_W = 4;
    localparam int PERF_W    = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_v;
    logic [INSN_W-1:0]    in_ins;
    logic                 in_rdy;
    logic                 flush;
    logic                 dec_en;
    logic [INSN_W-1:0]    dec_ins;
    logic                 dec_macro;
    logic [UOP_CNT_W-1:0] dec_uop_cnt;
    logic                 dec_regexc;
    logic                 out_v;
    logic                 out_rdy;
    logic [UOP_CNT_W-1:0] out_uop_idx;
    logic                 out_last;
    logic                 out_exc;
    logic [PERF_W-1:0]    perf_insn;
    logic [PERF_W-1:0]    perf_uop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qupls_decode_sequencer #(.INSN_W(INSN_W), .UOP_CNT_W(UOP_CNT_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .in_v(in_v), .in_ins(in_ins), .in_rdy(in_rdy),
        .flush(flush), .dec_en(dec_en), .dec_ins(dec_ins), .dec_macro(dec_macro),
        .dec_uop_cnt(dec_uop_cnt), .dec_regexc(dec_regexc), .out_v(out_v),
        .out_rdy(out_rdy), .out_uop_idx(out_uop_idx), .out_last(out_last),
        .out_exc(out_exc), .perf_insn(perf_insn), .perf_uop(perf_uop)
    );

    // Stand-in decoder: one-cycle output register loaded on dec_en.
    logic [INSN_W-1:0] dec_reg = '0;
    always @(posedge clk) if (dec_en) dec_reg <= in_ins;
    assign dec_macro   = dec_reg[0];
    assign dec_uop_cnt = dec_reg[4:1];
    assign dec_regexc  = dec_reg[5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [INSN_W-1:0] ins);
        if (ins[5]) return 1;
        if (ins[0]) return (ins[4:1] == 0) ? 1 : int'(ins[4:1]);
        return 1;
    endfunction

    // Model: the held instruction, how many beats it has issued, and issue totals.
    bit                held;
    logic [INSN_W-1:0] m_ins;
    int                m_idx;
    longint            m_insn, m_uop;

    task automatic apply(input bit r, input bit v, input logic [INSN_W-1:0] ins,
                         input bit rdy, input bit fl);
        @(posedge clk);
        #1;
        rst = r; in_v = v; in_ins = ins; out_rdy = rdy; flush = fl;
    endtask

    task automatic check_and_step();
        int  n;
        bit  e_last, e_rdy, e_en;
        #3;
        n      = beats_of(m_ins);
        e_last = held && (m_idx == n - 1);
        e_rdy  = !flush && (!held || (out_rdy && e_last));
        e_en   = in_v && e_rdy;
        check("out_v", 64'(out_v), 64'(held));
        check("in_rdy", 64'(in_rdy), 64'(e_rdy));
        check("dec_en", 64'(dec_en), 64'(e_en));
        check("dec_ins", 64'(dec_ins), 64'(in_ins));
        check("perf_insn", 64'(perf_insn), 64'(m_insn % (64'd1 << PERF_W)));
        check("perf_uop", 64'(perf_uop), 64'(m_uop % (64'd1 << PERF_W)));
        if (held) begin
            check("out_uop_idx", 64'(out_uop_idx), 64'(m_idx));
            check("out_last", 64'(out_last), 64'(e_last));
            check("out_exc", 64'(out_exc), 64'(m_ins[5]));
        end else begin
            check("idle_idx", 64'(out_uop_idx), 64'(0));
        end
        if (rst) begin
            held = 0; m_idx = 0; m_insn = 0; m_uop = 0;
        end else if (flush) begin
            held = 0; m_idx = 0;
        end else begin
            if (held && out_rdy) begin
                m_uop++;
                if (e_last) begin
                    m_insn++; m_idx = 0; held = 0;
                end else begin
                    m_idx++;
                end
            end
            if (e_en) begin
                held = 1; m_ins = in_ins; m_idx = 0;
            end
        end
    endtask

    function automatic logic [INSN_W-1:0] rand_ins();
        logic [INSN_W-1:0] ins;
        ins    = {$urandom, $urandom};
        ins[5] = ($urandom_range(0, 7) == 0);
        ins[0] = ($urandom_range(0, 1) == 1);
        return ins;
    endfunction

    initial begin
        rst = 1; in_v = 0; in_ins = '0; out_rdy = 0; flush = 0;
        held = 0; m_ins = '0; m_idx = 0; m_insn = 0; m_uop = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #3;
        check("rst_out_v", 64'(out_v), 64'(0));
        check("rst_idx", 64'(out_uop_idx), 64'(0));
        check("rst_exc", 64'(out_exc), 64'(0));
        check("rst_in_rdy", 64'(in_rdy), 64'(1));
        check("rst_perf_insn", 64'(perf_insn), 64'(0));
        check("rst_perf_uop", 64'(perf_uop), 64'(0));

        // Directed boundary cases: zero count, exception on a macro, 3-beat macro with backpressure.
        apply(0, 1, 48'h0000_0000_0001, 1, 0); check_and_step();
        apply(0, 1, 48'h0000_0000_0029, 1, 0); check_and_step();
        apply(0, 1, 48'h0000_0000_0007, 1, 0); check_and_step();
        apply(0, 0, '0, 1, 0); check_and_step();
        apply(0, 0, '0, 0, 0); check_and_step();
        apply(0, 0, '0, 1, 0); check_and_step();
        apply(0, 0, '0, 1, 0); check_and_step();
        apply(0, 0, '0, 1, 0); check_and_step();

        for (int i = 0; i < 4000; i++) begin
            apply($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  rand_ins(),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            check_and_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
